dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder that serves load/store requests issued by the pipeline memory stage over a request/ready handshake.
- Supports word, halfword and byte accesses, with load sign/zero extension and store byte-lane merging.
- Adds a configurable number of wait states, so the memory stage can be exercised against a multi-cycle memory.
- Emits a one-cycle write-log record for every committed store, used by the trace checker.

Parameters:
ADDR_BITS, 12, word-index width; storage holds 2^ADDR_BITS 32-bit words indexed by Addr[ADDR_BITS+1:2]; upper address bits ignored (aliasing)
WAIT_CYCLES, 2, extra cycles between request acceptance and the access edge (0..15)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Req  input  1  request valid; sampled only while Busy=0
Write  input  1  1=store, 0=load
Addr  input  32  byte address
WD  input  32  store data; low byte/half used for narrow stores
OpWidth  input  2  00 word, 01 half, 10 byte, 11 reserved
LoadSigned  input  1  1=sign-extend narrow loads, 0=zero-extend
WPC  input  32  PC of the requesting instruction, for logging
Busy  output  1  high from the acceptance edge until the access edge
Ready  output  1  one-cycle completion pulse
RD  output  32  load result; valid only while Ready=1
AlignErr  output  1  pulses with Ready when the request was misaligned or reserved
LogValid  output  1  one-cycle pulse when a store commits
LogPC  output  32  WPC of the committed store
LogAddr  output  32  word-aligned address of the committed store ({Addr[31:2],2'b00})
LogData  output  32  full merged word written

Behaviour:
- Reset (async): state IDLE; all storage words 0; Busy, Ready, AlignErr, LogValid = 0; RD, LogPC, LogAddr, LogData = 0. Reset asserted mid-transaction aborts it: no write, no Ready.
- States: IDLE and ACCESS. 4-bit wait counter cnt.
- IDLE, Req=1 at edge k:
  - latch Write, Addr, WD, OpWidth, LoadSigned and WPC;
  - load cnt=WAIT_CYCLES; go to ACCESS; Busy=1 from edge k.
- ACCESS, cnt!=0: cnt decrements each edge.
- ACCESS, cnt==0 (the access edge): perform the access; Ready<=1; go to IDLE; Busy<=0.
- Access-edge timing: the access edge is k+1+WAIT_CYCLES; Ready is high for exactly the following cycle.
- Req while Busy=1 is ignored: not queued, latched fields unchanged.
- Back-to-back: during the Ready cycle the state is IDLE, so Req=1 is accepted at that cycle's ending edge. Sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Misalignment: half with Addr[0]=1, word with Addr[1:0]!=0, or OpWidth=11.
  - Ready=1 and AlignErr=1 on the access edge; RD=0.
  - No storage write and no LogValid.
- Byte lanes are little-endian:
  - byte n=Addr[1:0] occupies bits [8n+7:8n];
  - half occupies bits [16*Addr[1]+15:16*Addr[1]].
- Store: only the selected lanes change, taking WD[7:0] (byte), WD[15:0] (half) or WD (word).
  - LogValid=1 with the Ready cycle; LogData is the merged word.
- Load: RD is the selected lane, sign- or zero-extended per LoadSigned; word loads ignore LoadSigned. RD holds its value after Ready falls but is only defined while Ready=1.
- Hazard: a load accepted right after a store to the same word returns the post-store value.
- Storage is written only at the access edge; no combinational read path from Req to RD.

Test Plan:
- WAIT_CYCLES=2, Reset released, then store word 0x12345678 to Addr 0x0000_0010 at edge k:
  - Busy=1 for cycles k..k+2;
  - Ready, LogValid=1 in cycle k+3 only;
  - LogAddr=0x10, LogData=0x12345678.
- Byte/half merge:
  - after the word above, store byte WD=0xAB to 0x13: LogData=0xAB345678;
  - store half WD=0xCDEF to 0x10: LogData=0xAB34CDEF.
- Load extension at 0x13 (byte 0xAB):
  - LoadSigned=1 -> RD=0xFFFFFFAB; LoadSigned=0 -> RD=0x000000AB;
  - half at 0x12, signed -> RD=0xFFFFAB34.
- Misaligned store half to 0x11:
  - Ready=1 and AlignErr=1 together, LogValid=0;
  - a subsequent word load at 0x10 returns the unchanged value 0xAB34CDEF.
- Req held high continuously for 3 loads, WAIT_CYCLES=0:
  - Ready pulses every 2nd cycle;
  - Req during Busy is ignored: exactly 3 Ready pulses over 6 cycles.
- Reset pulse one cycle after accepting a store to 0x20:
  - Ready never rises; Busy=0 immediately;
  - a later word load of 0x20 returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: serves word/half/byte loads and stores after a fixed
// number of wait states and emits a one-cycle write-log record per committed store.
module dm_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        Write,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic [1:0]  OpWidth,
   input  logic        LoadSigned,
   input  logic [31:0] WPC,
   output logic        Busy,
   output logic        Ready,
   output logic [31:0] RD,
   output logic        AlignErr,
   output logic        LogValid,
   output logic [31:0] LogPC,
   output logic [31:0] LogAddr,
   output logic [31:0] LogData
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic [1:0]  opw_q, opw_d;
   logic        lsgn_q, lsgn_d;
   logic [31:0] wpc_q, wpc_d;

   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic        alignerr_q, alignerr_d;
   logic        logvalid_q, logvalid_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] logpc_q, logpc_d;
   logic [31:0] logaddr_q, logaddr_d;
   logic [31:0] logdata_q, logdata_d;

   logic [31:0]          mem_q [DEPTH];
   logic                 mem_we_d;
   logic [31:0]          mem_wdata_d;
   logic [ADDR_BITS-1:0] widx;
   logic [31:0]          old_word;
   logic [31:0]          merged_word;
   logic [31:0]          load_val;
   logic                 mis;

   function automatic logic misaligned(input logic [1:0] opw, input logic [1:0] lo);
      logic r;
      case (opw)
         2'b00:   r = (lo != 2'b00);
         2'b01:   r = lo[0];
         2'b10:   r = 1'b0;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] opw, input logic [1:0] lo);
      logic [31:0] r;
      r = old;
      case (opw)
         2'b00:   r = wd;
         2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
         2'b10:   r[{lo, 3'b000} +: 8] = wd[7:0];
         default: r = old;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] opw,
                                                input logic [1:0] lo, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lo, 3'b000} +: 8];
      h = w[{lo[1], 4'b0000} +: 16];
      case (opw)
         2'b01:   r = {{16{sgn & h[15]}}, h};
         2'b10:   r = {{24{sgn & b[7]}}, b};
         default: r = w;
      endcase
      return r;
   endfunction

   assign widx        = addr_q[ADDR_BITS+1:2];
   assign old_word    = mem_q[widx];
   assign mis         = misaligned(opw_q, addr_q[1:0]);
   assign merged_word = merge_lanes(old_word, wd_q, opw_q, addr_q[1:0]);
   assign load_val    = extract_lane(old_word, opw_q, addr_q[1:0], lsgn_q);

   // Next-state, request capture and access-edge result computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wd_d        = wd_q;
      opw_d       = opw_q;
      lsgn_d      = lsgn_q;
      wpc_d       = wpc_q;
      busy_d      = busy_q;
      ready_d     = 1'b0;
      alignerr_d  = 1'b0;
      logvalid_d  = 1'b0;
      rd_d        = rd_q;
      logpc_d     = logpc_q;
      logaddr_d   = logaddr_q;
      logdata_d   = logdata_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = merged_word;
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               write_d = Write;
               addr_d  = Addr;
               wd_d    = WD;
               opw_d   = OpWidth;
               lsgn_d  = LoadSigned;
               wpc_d   = WPC;
               cnt_d   = WAIT_INIT;
               state_d = ST_ACCESS;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               ready_d    = 1'b1;
               alignerr_d = mis;
               // Misaligned or reserved requests complete without touching storage.
               if (mis) begin
                  rd_d = 32'h0000_0000;
               end else if (write_q) begin
                  rd_d       = 32'h0000_0000;
                  mem_we_d   = 1'b1;
                  logvalid_d = 1'b1;
                  logpc_d    = wpc_q;
                  logaddr_d  = {addr_q[31:2], 2'b00};
                  logdata_d  = merged_word;
               end else begin
                  rd_d = load_val;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control, latched request and registered output flops.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         write_q    <= 1'b0;
         addr_q     <= 32'h0000_0000;
         wd_q       <= 32'h0000_0000;
         opw_q      <= 2'b00;
         lsgn_q     <= 1'b0;
         wpc_q      <= 32'h0000_0000;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         alignerr_q <= 1'b0;
         logvalid_q <= 1'b0;
         rd_q       <= 32'h0000_0000;
         logpc_q    <= 32'h0000_0000;
         logaddr_q  <= 32'h0000_0000;
         logdata_q  <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         opw_q      <= opw_d;
         lsgn_q     <= lsgn_d;
         wpc_q      <= wpc_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         alignerr_q <= alignerr_d;
         logvalid_q <= logvalid_d;
         rd_q       <= rd_d;
         logpc_q    <= logpc_d;
         logaddr_q  <= logaddr_d;
         logdata_q  <= logdata_d;
      end
   end

   // Word storage, cleared by reset and written only on a committing access edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (mem_we_d) begin
         mem_q[widx] <= mem_wdata_d;
      end
   end

   assign Busy     = busy_q;
   assign Ready    = ready_q;
   assign RD       = rd_q;
   assign AlignErr = alignerr_q;
   assign LogValid = logvalid_q;
   assign LogPC    = logpc_q;
   assign LogAddr  = logaddr_q;
   assign LogData  = logdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: two instances (2 and 0 wait states) share
// stimulus and are compared against a word-array reference model.
module tb_dm_responder;

   localparam int WA = 2;
   localparam int WB = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, wr, lsgn;
   logic [31:0] addr, wd, wpc;
   logic [1:0]  opw;

   logic        busy_a, ready_a, ae_a, lv_a;
   logic [31:0] rd_a, lpc_a, la_a, ld_a;
   logic        busy_b, ready_b, ae_b, lv_b;
   logic [31:0] rd_b, lpc_b, la_b, ld_b;

   logic [31:0] mdl [4096];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dm_responder #(.ADDR_BITS(12), .WAIT_CYCLES(WA)) dut_a (
      .Clk(clk), .Reset(rst), .Req(req), .Write(wr), .Addr(addr), .WD(wd),
      .OpWidth(opw), .LoadSigned(lsgn), .WPC(wpc),
      .Busy(busy_a), .Ready(ready_a), .RD(rd_a), .AlignErr(ae_a), .LogValid(lv_a),
      .LogPC(lpc_a), .LogAddr(la_a), .LogData(ld_a));

   dm_responder #(.ADDR_BITS(12), .WAIT_CYCLES(WB)) dut_b (
      .Clk(clk), .Reset(rst), .Req(req), .Write(wr), .Addr(addr), .WD(wd),
      .OpWidth(opw), .LoadSigned(lsgn), .WPC(wpc),
      .Busy(busy_b), .Ready(ready_b), .RD(rd_b), .AlignErr(ae_b), .LogValid(lv_b),
      .LogPC(lpc_b), .LogAddr(la_b), .LogData(ld_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit mdl_mis(input logic [1:0] ow, input logic [31:0] a);
      return (ow == 2'd3) || (ow == 2'd1 && a[0]) || (ow == 2'd0 && a[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] mdl_mask(input logic [1:0] ow);
      return (ow == 2'd2) ? 32'h0000_00FF : (ow == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] mdl_store(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] ow, input logic [31:0] a);
      int sh;
      logic [31:0] m;
      sh = 8 * int'(a[1:0]);
      m  = mdl_mask(ow);
      return (old & ~(m << sh)) | ((d & m) << sh);
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] word, input logic [1:0] ow,
                                            input logic [31:0] a, input bit ls);
      int sh;
      logic [31:0] v;
      sh = 8 * int'(a[1:0]);
      v  = (word >> sh) & mdl_mask(ow);
      if (ls && ow == 2'd2 && v[7])  v = v | 32'hFFFF_FF00;
      if (ls && ow == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic inst_chk(input string nm, input int w, input int c, input bit is_wr, input bit m,
                           input logic [31:0] exp_rd, input logic [31:0] exp_ld,
                           input logic [31:0] exp_pc, input logic [31:0] exp_la,
                           input logic bsy, input logic rdy, input logic ae, input logic lv,
                           input logic [31:0] rd, input logic [31:0] lpc,
                           input logic [31:0] la, input logic [31:0] ld);
      bit at;
      at = (c == w + 1);
      chk({nm, "_busy"},     32'(bsy), 32'(c <= w));
      chk({nm, "_ready"},    32'(rdy), 32'(at));
      chk({nm, "_alignerr"}, 32'(ae),  32'(at && m));
      chk({nm, "_logvalid"}, 32'(lv),  32'(at && is_wr && !m));
      if (at && (!is_wr || m)) chk({nm, "_rd"}, rd, exp_rd);
      if (at && is_wr && !m) begin
         chk({nm, "_logpc"},   lpc, exp_pc);
         chk({nm, "_logaddr"}, la,  exp_la);
         chk({nm, "_logdata"}, ld,  exp_ld);
      end
   endtask

   // Issue one request at a falling edge and check both instances cycle by cycle.
   task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] ow, input logic ls, input logic [31:0] pc,
                         output logic [31:0] o_rd, output logic [31:0] o_ld);
      int          idx;
      bit          m;
      logic [31:0] neww, exp_rd;
      idx    = int'(a[13:2]);
      m      = mdl_mis(ow, a);
      neww   = mdl_store(mdl[idx], d, ow, a);
      exp_rd = m ? 32'h0 : mdl_load(mdl[idx], ow, a, ls);
      o_rd   = 32'h0;
      o_ld   = 32'h0;
      req = 1'b1; wr = w; addr = a; wd = d; opw = ow; lsgn = ls; wpc = pc;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      for (int c = 0; c <= WA + 1; c++) begin
         if (c > 0) @(negedge clk);
         inst_chk("a", WA, c, w, m, exp_rd, neww, pc, {a[31:2], 2'b00},
                  busy_a, ready_a, ae_a, lv_a, rd_a, lpc_a, la_a, ld_a);
         inst_chk("b", WB, c, w, m, exp_rd, neww, pc, {a[31:2], 2'b00},
                  busy_b, ready_b, ae_b, lv_b, rd_b, lpc_b, la_b, ld_b);
         if (c == WA + 1) begin
            o_rd = rd_a;
            o_ld = ld_a;
         end
      end
      if (w && !m) mdl[idx] = neww;
   endtask

   initial begin
      logic [31:0] g_rd, g_ld, r, a;
      logic [2:0]  ix;
      logic [1:0]  lo;
      int          npulse, t;

      for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
      rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 32'h0; wd = 32'h0;
      opw = 2'b00; lsgn = 1'b0; wpc = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_busy",     32'(busy_a),  32'h0);
      chk("rst_ready",    32'(ready_a), 32'h0);
      chk("rst_alignerr", 32'(ae_a),    32'h0);
      chk("rst_logvalid", 32'(lv_a),    32'h0);
      chk("rst_rd",       rd_a,         32'h0);
      chk("rst_logpc",    lpc_a,        32'h0);
      chk("rst_logaddr",  la_a,         32'h0);
      chk("rst_logdata",  ld_a,         32'h0);
      chk("rst_b_busy",   32'(busy_b),  32'h0);
      chk("rst_b_ready",  32'(ready_b), 32'h0);

      // Directed sequence from the plan.
      do_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 2'b00, 1'b0, 32'h0000_1000, g_rd, g_ld);
      chk("tp_word_store", g_ld, 32'h1234_5678);
      do_txn(1'b1, 32'h0000_0013, 32'h0000_00AB, 2'b10, 1'b0, 32'h0000_1004, g_rd, g_ld);
      chk("tp_byte_merge", g_ld, 32'hAB34_5678);
      do_txn(1'b1, 32'h0000_0010, 32'h0000_CDEF, 2'b01, 1'b0, 32'h0000_1008, g_rd, g_ld);
      chk("tp_half_merge", g_ld, 32'hAB34_CDEF);
      do_txn(1'b0, 32'h0000_0013, 32'h0, 2'b10, 1'b1, 32'h0000_100C, g_rd, g_ld);
      chk("tp_lb_signed", g_rd, 32'hFFFF_FFAB);
      do_txn(1'b0, 32'h0000_0013, 32'h0, 2'b10, 1'b0, 32'h0000_1010, g_rd, g_ld);
      chk("tp_lb_unsigned", g_rd, 32'h0000_00AB);
      do_txn(1'b0, 32'h0000_0012, 32'h0, 2'b01, 1'b1, 32'h0000_1014, g_rd, g_ld);
      chk("tp_lh_signed", g_rd, 32'hFFFF_AB34);
      do_txn(1'b1, 32'h0000_0011, 32'h0000_5555, 2'b01, 1'b0, 32'h0000_1018, g_rd, g_ld);
      do_txn(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0, 32'h0000_101C, g_rd, g_ld);
      chk("tp_after_misaligned", g_rd, 32'hAB34_CDEF);

      // Req held high: the zero-wait instance must complete every second cycle.
      req = 1'b1; wr = 1'b0; addr = 32'h0000_0010; opw = 2'b00; lsgn = 1'b0;
      npulse = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("cr_ready", 32'(ready_b), 32'(c % 2 == 1));
         chk("cr_busy",  32'(busy_b),  32'(c % 2 == 0));
         if (ready_b) begin
            npulse++;
            chk("cr_rd", rd_b, 32'hAB34_CDEF);
         end
      end
      req = 1'b0;
      chk("cr_pulses", 32'(npulse), 32'd3);
      t = 0;
      while ((busy_a || busy_b) && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("cr_drain", 32'(busy_a || busy_b), 32'h0);
      @(negedge clk);

      // Randomized traffic over a small set of words with aliased upper bits.
      for (int n = 0; n < 60; n++) begin
         r  = $urandom();
         ix = 3'($urandom_range(0, 7));
         lo = 2'($urandom_range(0, 3));
         a  = {r[31:14], 9'd0, ix, lo};
         do_txn(1'($urandom_range(0, 1)), a, $urandom(), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom(), g_rd, g_ld);
      end

      // Reset one cycle after accepting a store aborts it entirely.
      req = 1'b1; wr = 1'b1; addr = 32'h0000_0020; wd = 32'hDEAD_BEEF; opw = 2'b00;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk("ab_busy_before", 32'(busy_a), 32'h1);
      rst = 1'b1;
      #1;
      chk("ab_busy_a", 32'(busy_a), 32'h0);
      chk("ab_busy_b", 32'(busy_b), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("ab_ready_a", 32'(ready_a || lv_a), 32'h0);
         chk("ab_ready_b", 32'(ready_b || lv_b), 32'h0);
      end
      do_txn(1'b0, 32'h0000_0020, 32'h0, 2'b00, 1'b0, 32'h0000_2000, g_rd, g_ld);
      chk("ab_load_after", g_rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
